// File: rtl/line_clear_pkg.sv
// line_clear_pkg
//   Shared board geometry, brick width, FSM state encoding and the
//   row/cell bit-offset helpers used by the line-clear engine.
//   Cell (x,y) lives at bits [cell_lsb(x,y,w,c) +: c]; row y starts at
//   row_lsb(y,w,c). Row 0 is the top row, stored in the lowest bits.
package line_clear_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int BRICK_LEN   = 3;
  localparam int BOARD_SIZE  = BOARD_W_DEF * BOARD_H_DEF * BRICK_LEN;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } lc_state_e;

  // Bit offset of cell (x,y) in a packed board of width w and cell size c.
  function automatic int cell_lsb(input int x, input int y, input int w, input int c);
    return (y * w + x) * c;
  endfunction

  // Bit offset of the first cell of row y.
  function automatic int row_lsb(input int y, input int w, input int c);
    return y * w * c;
  endfunction

endpackage

// File: rtl/line_clear_row_full.sv
// line_clear_row_full
//   Combinational check that every cell of one board row is occupied.
//   Ports:
//     row  - one packed row, BOARD_W cells of CELL_W bits each
//     full - 1 when no cell in the row is zero
module line_clear_row_full
  import line_clear_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int CELL_W  = BRICK_LEN
) (
  input  logic [BOARD_W*CELL_W-1:0] row,
  output logic                      full
);

  // AND-reduce the per-cell "occupied" flags across the row.
  always_comb begin
    full = 1'b1;
    for (int x = 0; x < BOARD_W; x++) begin
      full = full & (|row[cell_lsb(x, 0, BOARD_W, CELL_W) +: CELL_W]);
    end
  end

endmodule

// File: rtl/line_clear.sv
// line_clear
//   Scans a latched copy of the board from the bottom row upwards, and
//   for every full row shifts everything above it down by one, refilling
//   the top row with zeros. The compacted board and the number of rows
//   removed are published together with a one-cycle done pulse.
//   Ports:
//     clk       - system clock
//     rst       - synchronous active-low reset
//     start     - request to process board_in (ignored while busy or in reset)
//     board_in  - source board, cell (x,y) at [(y*BOARD_W+x)*CELL_W +: CELL_W]
//     board_out - compacted board from the last completed operation
//     busy      - high from the cycle after start until the done cycle
//     done      - one-cycle completion pulse
//     lines     - rows cleared by the last completed operation
module line_clear
  import line_clear_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int CELL_W  = BRICK_LEN
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [BOARD_W*BOARD_H*CELL_W-1:0] board_in,
  output logic [BOARD_W*BOARD_H*CELL_W-1:0] board_out,
  output logic                              busy,
  output logic                              done,
  output logic [4:0]                        lines
);

  localparam int ROW_BITS   = BOARD_W * CELL_W;
  localparam int BOARD_BITS = BOARD_W * BOARD_H * CELL_W;
  localparam int PTR_W      = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;

  localparam logic [PTR_W-1:0] PTR_TOP   = PTR_W'(BOARD_H - 1);
  localparam logic [4:0]       LINES_MAX = 5'(BOARD_H);

  lc_state_e             state_r;
  logic [PTR_W-1:0]      ptr_r;
  logic [BOARD_BITS-1:0] board_r;
  logic [BOARD_BITS-1:0] board_out_r;
  logic [4:0]            lines_r;
  logic [4:0]            lines_out_r;
  logic                  busy_r;
  logic                  done_r;

  logic [ROW_BITS-1:0]   row_sel_s;
  logic                  row_full_s;
  logic [BOARD_BITS-1:0] shifted_s;

  // Select the row addressed by the scan pointer.
  always_comb begin
    row_sel_s = board_r[ROW_BITS-1:0];
    for (int y = 0; y < BOARD_H; y++) begin
      if (ptr_r == PTR_W'(y)) begin
        row_sel_s = board_r[row_lsb(y, BOARD_W, CELL_W) +: ROW_BITS];
      end else begin
        row_sel_s = row_sel_s;
      end
    end
  end

  line_clear_row_full #(
    .BOARD_W (BOARD_W),
    .CELL_W  (CELL_W)
  ) u_row_full (
    .row  (row_sel_s),
    .full (row_full_s)
  );

  // Board after removing the pointer row: rows 1..ptr take the row above,
  // row 0 is refilled empty, rows below the pointer keep their contents.
  // With ptr = 0 this only clears row 0.
  always_comb begin
    shifted_s = board_r;
    shifted_s[ROW_BITS-1:0] = '0;
    for (int y = 1; y < BOARD_H; y++) begin
      if (PTR_W'(y) <= ptr_r) begin
        shifted_s[row_lsb(y, BOARD_W, CELL_W) +: ROW_BITS] =
          board_r[row_lsb(y - 1, BOARD_W, CELL_W) +: ROW_BITS];
      end else begin
        shifted_s[row_lsb(y, BOARD_W, CELL_W) +: ROW_BITS] =
          board_r[row_lsb(y, BOARD_W, CELL_W) +: ROW_BITS];
      end
    end
  end

  // Control FSM, working board and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      board_r     <= '0;
      board_out_r <= '0;
      lines_r     <= 5'd0;
      lines_out_r <= 5'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          // busy_r is still high during the done cycle, so a start that
          // coincides with done is treated as arriving while busy.
          if (start && !busy_r) begin
            board_r <= board_in;
            ptr_r   <= PTR_TOP;
            lines_r <= 5'd0;
            busy_r  <= 1'b1;
            state_r <= ST_SCAN;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (row_full_s) begin
            lines_r <= (lines_r >= LINES_MAX) ? LINES_MAX : lines_r + 5'd1;
            state_r <= ST_SHIFT;
          end else if (ptr_r != '0) begin
            ptr_r   <= ptr_r - PTR_W'(1);
          end else begin
            state_r <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          // Pointer is kept: the row that dropped into it must be rescanned.
          board_r <= shifted_s;
          state_r <= ST_SCAN;
        end
        ST_DONE: begin
          done_r      <= 1'b1;
          board_out_r <= board_r;
          lines_out_r <= lines_r;
          state_r     <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign board_out = board_out_r;
  assign lines     = lines_out_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_line_clear.sv
// tb_line_clear
//   Directed self-checking bench for line_clear with default geometry
//   (10 x 20 board, 3-bit cells). Expected boards, line counts and
//   start-to-done latencies are computed by hand from the board contents.
module tb_line_clear;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int C  = 3;
  localparam int BS = W * H * C;

  logic          clk;
  logic          rst;
  logic          start;
  logic [BS-1:0] board_in;
  logic [BS-1:0] board_out;
  logic          busy;
  logic          done;
  logic [4:0]    lines;

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;

  logic [BS-1:0] b_a;
  logic [BS-1:0] exp_b;
  logic [BS-1:0] all7;
  int            base_cnt;

  line_clear u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .board_in  (board_in),
    .board_out (board_out),
    .busy      (busy),
    .done      (done),
    .lines     (lines)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [BS-1:0] put(input logic [BS-1:0] b, input int x, input int y,
                                        input logic [2:0] v);
    logic [BS-1:0] r;
    r = b;
    r[(y * W + x) * C +: C] = v;
    return r;
  endfunction

  function automatic logic [BS-1:0] fill_row(input logic [BS-1:0] b, input int y,
                                             input logic [2:0] v);
    logic [BS-1:0] r;
    r = b;
    for (int x = 0; x < W; x++) r = put(r, x, y, v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_board(input string tag, input logic [BS-1:0] obs, input logic [BS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge and measure cycles until done. With disturb
  // set, a second start and a new board_in are applied mid-operation.
  task automatic run(input string tag, input int exp_lat, input bit disturb);
    int lat;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (disturb && n == 4) begin
        start    = 1'b1;
        board_in = all7;
      end else if (disturb && n == 5) begin
        start = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    board_in = '0;
    all7     = '0;
    for (int y = 0; y < H; y++) all7 = fill_row(all7, y, 3'd7);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_lines", {27'd0, lines}, 32'd0);
    chk_board("rst_board", board_out, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Empty board: 20 scans + 1
    board_in = '0;
    run("empty", 21, 1'b0);
    chk("empty_lines", {27'd0, lines}, 32'd0);
    chk_board("empty_board", board_out, '0);

    // Bottom row full, single brick above it drops into row 19
    b_a = fill_row('0, 19, 3'd1);
    b_a = put(b_a, 0, 18, 3'd3);
    board_in = b_a;
    run("one", 23, 1'b0);
    chk("one_lines", {27'd0, lines}, 32'd1);
    chk_board("one_board", board_out, put('0, 0, 19, 3'd3));

    // Four full rows 16..19, brick (4,15) ends at (4,19)
    board_in = '0;
    for (int y = 16; y < 20; y++) begin
      for (int x = 0; x < W; x++) board_in = put(board_in, x, y, 3'((x % 7) + 1));
    end
    board_in = put(board_in, 4, 15, 3'd5);
    run("four", 29, 1'b0);
    chk("four_lines", {27'd0, lines}, 32'd4);
    chk_board("four_board", board_out, put('0, 4, 19, 3'd5));

    // Non-adjacent full rows 19 and 17
    board_in = fill_row('0, 19, 3'd2);
    board_in = fill_row(board_in, 17, 3'd6);
    board_in = put(board_in, 2, 18, 3'd4);
    board_in = put(board_in, 9, 16, 3'd6);
    exp_b = put('0, 2, 19, 3'd4);
    exp_b = put(exp_b, 9, 18, 3'd6);
    run("gap", 25, 1'b0);
    chk("gap_lines", {27'd0, lines}, 32'd2);
    chk_board("gap_board", board_out, exp_b);

    // Only the top row full: clearing at pointer 0 just zeros row 0
    board_in = fill_row('0, 0, 3'd3);
    board_in = put(board_in, 3, 19, 3'd2);
    run("top", 23, 1'b0);
    chk("top_lines", {27'd0, lines}, 32'd1);
    chk_board("top_board", board_out, put('0, 3, 19, 3'd2));

    // Every cell full: lines saturates at 20
    board_in = all7;
    run("all", 61, 1'b0);
    chk("all_lines", {27'd0, lines}, 32'd20);
    chk_board("all_board", board_out, '0);

    // Outputs hold after done while board_in changes
    board_in = b_a;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_lines", {27'd0, lines}, 32'd20);
    chk_board("hold_board", board_out, '0);

    // Second start and new board_in while busy are ignored
    base_cnt = done_cnt;
    board_in = b_a;
    run("busy", 23, 1'b1);
    chk("busy_lines", {27'd0, lines}, 32'd1);
    chk_board("busy_board", board_out, put('0, 0, 19, 3'd3));
    repeat (30) @(posedge clk);
    #1;
    chk("busy_one_done", done_cnt - base_cnt, 32'd1);

    // Reset mid-operation, with a start in the reset cycle
    base_cnt = done_cnt;
    board_in = b_a;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_lines", {27'd0, lines}, 32'd0);
    chk_board("abort_board", board_out, '0);
    rst   = 1'b1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - base_cnt, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    // Normal operation after the abort
    board_in = b_a;
    run("after", 23, 1'b0);
    chk("after_lines", {27'd0, lines}, 32'd1);
    chk_board("after_board", board_out, put('0, 0, 19, 3'd3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_clear.md
LINE_CLEAR -- requirements
Module: line_clear

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, meaning board columns.
REQ-002 SHALL have parameter BOARD_H, default 20, meaning board rows (row 0 = top, row BOARD_H-1 = bottom).
REQ-003 SHALL have parameter CELL_W, default `BRICK_LEN (3), meaning bits per cell; value 0 = empty, 1..7 = brick type.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-low, sampled on posedge clk.
REQ-006 SHALL have port start, input, 1, request to scan and clear board_in.
REQ-007 SHALL have port board_in, input, `BOARD_SIZE (BOARD_W*BOARD_H*CELL_W), board from the game FSM; cell (x,y) at bits [(y*BOARD_W+x)*CELL_W +: CELL_W].
REQ-008 SHALL have port board_out, output, `BOARD_SIZE, compacted board, same layout.
REQ-009 SHALL have port busy, output, 1, high from the cycle after start is accepted until the done cycle inclusive.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port lines, output, 5, number of rows cleared by the last operation (0..BOARD_H).

Function
REQ-012 SHALL implement FSM states IDLE, SCAN, SHIFT, DONE.
REQ-013 IDLE: start=1 at posedge SHALL latch board_in into the working board, set row pointer to BOARD_H-1, clear lines, and enter SCAN.
REQ-014 SCAN: one row per cycle; a row is full when all BOARD_W cells are nonzero.
REQ-015 SCAN, row full: SHALL enter SHIFT without changing the pointer and increment lines.
REQ-016 SCAN, row not full, pointer > 0: SHALL decrement the pointer and stay in SCAN.
REQ-017 SCAN, row not full, pointer = 0: SHALL enter DONE.
REQ-018 SHIFT: in one cycle, rows 0..ptr-1 SHALL move down one row, row 0 SHALL become all zero, rows ptr+1..BOARD_H-1 SHALL be unchanged, then return to SCAN on the same pointer.
REQ-019 SHIFT with ptr = 0 SHALL only zero row 0, then return to SCAN.
REQ-020 DONE: done=1 for exactly one cycle, board_out SHALL equal the working board, then return to IDLE.
REQ-021 Latency from the start edge to done high SHALL be BOARD_H + 2*k + 1 cycles, where k = rows cleared.
REQ-022 start while busy SHALL be ignored; board_in changes while busy SHALL have no effect.
REQ-023 board_out and lines SHALL hold their last DONE values until the next DONE or reset.
REQ-024 lines SHALL saturate at BOARD_H. An all-full board SHALL yield lines = BOARD_H and an all-zero board_out.

Reset
REQ-025 rst=0 at posedge SHALL force IDLE, board_out=0, working board=0, lines=0, busy=0, done=0, including mid-operation; no done pulse is issued for an aborted operation.
REQ-026 start SHALL be ignored in any cycle where rst=0.

Structure
REQ-027 BOARD_W, BOARD_H, `BOARD_SIZE, `BRICK_LEN, cell-index macro and FSM state encodings SHALL live in the shared header.v.
REQ-028 A combinational sub-module row_full (input one row, output 1-bit full) SHALL be instantiated once on the pointer-selected row.
REQ-029 All state SHALL update on posedge clk only, with no derived clocks.

Verification
REQ-030 Empty board, start pulse -> done at cycle 21, lines=0, board_out=0.
REQ-031 Row 19 full (type 1), row 18 cell (0,18)=3, start -> done at cycle 23, lines=1, cell (0,19)=3, all other cells 0.
REQ-032 Rows 16,17,18,19 full, (4,15)=5 -> done at cycle 29, lines=4, only cell (4,19)=5.
REQ-033 All 200 cells = 7 -> lines=20, board_out=0, done at cycle 61.
REQ-034 Start a scan, rst=0 at cycle 5 -> next cycle busy=0, board_out=0, no done; a start in the same cycle as rst=0 is ignored.
REQ-035 Second start pulse while busy -> ignored, and exactly one done pulse occurs.
